// File: rtl/fpnew_apu_adapter.sv
// rtl/fpnew_apu_adapter.sv - APU-to-FPU adapter with tagged requests, credit limit, response FIFO and flush.
// Optional same-cycle result bypass: define FPNEW_APU_BYPASS_EN.
module fpnew_apu_adapter #(
  parameter int ID_WIDTH        = 9,
  parameter int NB_ARGS         = 3,
  parameter int DATA_WIDTH      = 32,
  parameter int OPCODE_WIDTH    = 6,
  parameter int FLAGS_IN_WIDTH  = 15,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int RESP_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FMT_WIDTH       = (FLAGS_IN_WIDTH - 3) / 3,
  parameter int IFMT_WIDTH      = FLAGS_IN_WIDTH - 3 - 2 * FMT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic                            apu_req_i,
  output logic                            apu_gnt_o,
  input  logic [ID_WIDTH-1:0]             apu_ID_i,
  input  logic [NB_ARGS*DATA_WIDTH-1:0]   apu_operands_i,
  input  logic [OPCODE_WIDTH-1:0]         apu_op_i,
  input  logic [FLAGS_IN_WIDTH-1:0]       apu_flags_i,
  output logic                            apu_rvalid_o,
  input  logic                            apu_rready_i,
  output logic [DATA_WIDTH-1:0]           apu_rdata_o,
  output logic [FLAGS_OUT_WIDTH-1:0]      apu_rflags_o,
  output logic [ID_WIDTH-1:0]             apu_rID_o,
  output logic                            fpu_valid_o,
  input  logic                            fpu_ready_i,
  output logic [NB_ARGS*DATA_WIDTH-1:0]   fpu_operands_o,
  output logic [OPCODE_WIDTH-3:0]         fpu_op_o,
  output logic                            fpu_op_mod_o,
  output logic                            fpu_vec_op_o,
  output logic [2:0]                      fpu_rnd_o,
  output logic [FMT_WIDTH-1:0]            fpu_src_fmt_o,
  output logic [FMT_WIDTH-1:0]            fpu_dst_fmt_o,
  output logic [IFMT_WIDTH-1:0]           fpu_int_fmt_o,
  output logic [ID_WIDTH-1:0]             fpu_tag_o,
  output logic                            fpu_flush_o,
  input  logic                            fpu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]           fpu_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0]      fpu_rflags_i,
  input  logic [ID_WIDTH-1:0]             fpu_rtag_i,
  output logic                            busy_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int FW = $clog2(RESP_DEPTH + 1);
  localparam int EW = DATA_WIDTH + FLAGS_OUT_WIDTH + ID_WIDTH;

  generate
    if (MAX_OUTSTANDING > RESP_DEPTH) begin : g_bad_credit
      $error("MAX_OUTSTANDING must not exceed RESP_DEPTH");
    end
  endgenerate

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t        r_state;
  logic          r_flush;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [FW-1:0] r_fill;
  logic [EW-1:0] r_mem [RESP_DEPTH];

  logic          w_run;
  logic          w_avail;
  logic          w_empty;
  logic          w_full;
  logic          w_bypass;
  logic          w_rvalid;
  logic          w_hs;
  logic          w_pop;
  logic          w_push;
  logic          w_accept;
  logic [EW-1:0] w_fpu_resp;
  logic [EW-1:0] w_resp;

  assign {fpu_vec_op_o, fpu_op_mod_o, fpu_op_o} = apu_op_i;
  assign {fpu_int_fmt_o, fpu_src_fmt_o, fpu_dst_fmt_o, fpu_rnd_o} = apu_flags_i;
  assign fpu_operands_o = apu_operands_i;
  assign fpu_tag_o      = apu_ID_i;

  assign w_run    = (r_state == ST_RUN);
  assign w_avail  = (r_cnt < CW'(MAX_OUTSTANDING)) && w_run;
  assign fpu_valid_o = apu_req_i && w_avail;
  assign apu_gnt_o   = fpu_ready_i && w_avail;
  assign w_accept    = apu_req_i && apu_gnt_o;

  assign w_empty    = (r_fill == '0);
  assign w_full     = (r_fill == FW'(RESP_DEPTH));
  assign w_fpu_resp = {fpu_rdata_i, fpu_rflags_i, fpu_rtag_i};

`ifdef FPNEW_APU_BYPASS_EN
  assign w_bypass = w_empty && fpu_rvalid_i && apu_rready_i && w_run;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_rvalid = !w_empty || w_bypass;
  assign w_hs     = w_rvalid && apu_rready_i;
  assign w_pop    = w_hs && !w_empty;
  // A full FIFO still accepts a result when its head leaves in the same cycle.
  assign w_push   = fpu_rvalid_i && w_run && !w_bypass && (!w_full || w_pop);

  assign w_resp = w_bypass ? w_fpu_resp : (w_empty ? '0 : r_mem[r_rptr]);

  assign apu_rvalid_o  = w_rvalid;
  assign {apu_rdata_o, apu_rflags_o, apu_rID_o} = w_resp;
  assign fpu_flush_o   = r_flush;
  assign busy_o        = (r_cnt != '0);
  assign outstanding_o = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_fpu_resp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_flush <= 1'b0;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_fill  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (flush_i) begin
            r_state <= ST_FLUSH;
            r_flush <= 1'b1;
          end
          if (w_accept && !w_hs) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (!w_accept && w_hs) begin
            r_cnt <= r_cnt - 1'b1;
          end
          if (w_push) begin
            r_wptr <= (r_wptr == PW'(RESP_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
          end
          if (w_pop) begin
            r_rptr <= (r_rptr == PW'(RESP_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
          end
          if (w_push && !w_pop) begin
            r_fill <= r_fill + 1'b1;
          end else if (w_pop && !w_push) begin
            r_fill <= r_fill - 1'b1;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_flush <= 1'b0;
          r_cnt   <= '0;
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_fill  <= '0;
        end
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fpu_rvalid_i && w_run && !w_bypass && w_full && !w_pop));

endmodule
